// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, framing constants and parity helper for the TX and RX paths.
package uart_pkg;
  localparam int DATA_WIDTH = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload shift register, bit index and parity for the UART transmitter.
module uart_tx_serializer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  ser_bit,
  output logic                  par_bit,
  output logic                  last
);
  localparam int IW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] sreg;
  logic [IW-1:0] idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      idx <= '0;
      par_bit <= 1'b0;
    end else if (load) begin
      sreg <= data;
      idx <= '0;
      par_bit <= parity_bit(data, par_typ);
    end else begin
      if (shift) sreg <= sreg >> 1;
      if (step) idx <= idx + IW'(1);
    end
  end
  assign ser_bit = sreg[0];
  assign last = idx == IW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter; one handshaked byte per frame, start/data/optional parity/stop,
// each bit held for a latched prescale count of clk cycles.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  tx_out,
  output logic                  busy
);
  uart_state_e state, nxt;
  logic [PRESCALE_W-1:0] cnt, psc_l, psc_eff;
  logic par_en_l, ser_bit, par_bit, last, accept, bit_end;
  assign psc_eff = prescale == '0 ? PRESCALE_W'(1) : prescale;
  assign accept = state == IDLE && data_valid;
  assign bit_end = cnt == '0;
  always_comb begin
    nxt = state == START ? DATA :
          state == DATA ? (last ? (par_en_l ? PARITY : STOP) : DATA) :
          state == PARITY ? STOP : IDLE;
  end
  uart_tx_serializer u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .shift(bit_end && (state == START || state == DATA)),
    .step(bit_end && state == DATA),
    .data(P_DATA),
    .par_typ(par_typ),
    .ser_bit(ser_bit),
    .par_bit(par_bit),
    .last(last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      psc_l <= '0;
      par_en_l <= 1'b0;
      tx_out <= STOP_BIT;
      busy <= 1'b0;
    end else if (accept) begin
      psc_l <= psc_eff;
      par_en_l <= par_en;
      cnt <= psc_eff - PRESCALE_W'(1);
      tx_out <= START_BIT;
      busy <= 1'b1;
      state <= START;
    end else if (state != IDLE) begin
      if (bit_end) begin
        state <= nxt;
        cnt <= psc_l - PRESCALE_W'(1);
        tx_out <= nxt == DATA ? ser_bit : nxt == PARITY ? par_bit : STOP_BIT;
        busy <= nxt != IDLE;
      end else begin
        cnt <= cnt - PRESCALE_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame checks for uart_tx_frame with hand-computed serial patterns.
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic data_valid = 1'b0;
  logic tx_out, busy;
  int n_checks = 0;
  int n_fail = 0;

  uart_tx_frame dut (
    .clk(clk), .rst_n(rst_n), .prescale(prescale), .par_en(par_en), .par_typ(par_typ),
    .P_DATA(P_DATA), .data_valid(data_valid), .tx_out(tx_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples from the current negedge while busy; bit k is taken at sample k*p, the rest must agree.
  task automatic capture(input int p, output int len, output logic [31:0] bits, output int unstable);
    int idx;
    len = 0; bits = '0; unstable = 0;
    while (busy && len < 400) begin
      idx = len / p;
      if (idx < 32) begin
        if (len % p == 0) bits[idx] = tx_out;
        else if (tx_out !== bits[idx]) unstable++;
      end
      len++;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt);
    @(negedge clk);
    P_DATA = d; prescale = ps; par_en = pe; par_typ = pt; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic frame_test(input string tag, input logic [7:0] d, input logic [5:0] ps,
                            input int p, input logic pe, input logic pt,
                            input int exp_len, input logic [31:0] exp_bits);
    int len, unstable;
    logic [31:0] bits;
    send(d, ps, pe, pt);
    @(negedge clk);
    capture(p, len, bits, unstable);
    check({tag, "_len"}, len, exp_len);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_hold"}, unstable, 0);
    check({tag, "_idle_hi"}, tx_out, 1);
  endtask

  initial begin
    int bad, len, unstable, gap, cyc;
    logic [31:0] bits;
    #12;
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle20", bad, 0);

    frame_test("a5_p8", 8'hA5, 6'd8, 8, 1'b0, 1'b0, 80, 32'h34A);
    frame_test("07_even", 8'h07, 6'd16, 16, 1'b1, 1'b0, 176, 32'h60E);
    frame_test("07_odd", 8'h07, 6'd16, 16, 1'b1, 1'b1, 176, 32'h40E);
    frame_test("81_p0", 8'h81, 6'd0, 1, 1'b0, 1'b0, 10, 32'h302);
    frame_test("81_p1", 8'h81, 6'd1, 1, 1'b0, 1'b0, 10, 32'h302);

    send(8'h3C, 6'd8, 1'b0, 1'b0);
    P_DATA = 8'hFF; prescale = 6'd4; par_typ = 1'b1;
    @(negedge clk);
    capture(8, len, bits, unstable);
    check("shadow_len", len, 80);
    check("shadow_bits", bits, 32'h278);
    check("shadow_hold", unstable, 0);

    @(negedge clk);
    P_DATA = 8'h55; prescale = 6'd4; par_en = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    capture(4, len, bits, unstable);
    check("b2b1_len", len, 40);
    check("b2b1_bits", bits, 32'h2AA);
    gap = 0;
    while (!busy && gap < 50) begin
      if (tx_out !== 1'b1) bad++;
      gap++;
      @(negedge clk);
    end
    check("b2b_gap", gap, 1);
    data_valid = 1'b0;
    capture(4, len, bits, unstable);
    check("b2b2_len", len, 40);
    check("b2b2_bits", bits, 32'h2AA);
    check("b2b_hold", unstable, 0);

    repeat (5) @(negedge clk);
    send(8'h55, 6'd4, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 10) data_valid = 1'b1;
      if (i == 11) data_valid = 1'b0;
      cyc += int'(busy);
    end
    check("drop_busy_cycles", cyc, 40);

    send(8'h00, 6'd8, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_pre_tx", tx_out, 0);
    check("abort_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx_out, 1);
    check("abort_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_abort_idle", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
